// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage extended-Hamming (SECDED) decoder with valid/ready on both sides.
// Stage 1 computes the syndrome and overall parity. Stage 2 corrects the word, classifies it and counts errors.
module hamming_secded_stream_decoder #(
  parameter  int R     = 3,
  parameter  int CNT_W = 16,
  localparam int N     = 2**R,
  localparam int K     = N - R - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     code_in_i,
  input  logic             corr_en_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [K-1:0]     data_out_o,
  output logic             err_single_o,
  output logic             err_double_o,
  output logic [R-1:0]     err_pos_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] single_cnt_o,
  output logic [CNT_W-1:0] double_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // XOR of the indices of all set bits in positions 1..N-1.
  function automatic logic [R-1:0] syndrome(input logic [N-1:0] c);
    logic [R-1:0] s;
    logic [R-1:0] idx;
    s = '0;
    for (int i = 1; i < N; i++) begin
      idx = R'(i);
      if (c[idx]) s = s ^ idx;
    end
    return s;
  endfunction

  // Data bits occupy the non-power-of-two positions, lowest position first.
  function automatic logic [K-1:0] extract_data(input logic [N-1:0] c);
    logic [K-1:0] d;
    logic [R-1:0] idx;
    int           k;
    d = '0;
    k = 0;
    for (int i = 1; i < N; i++) begin
      idx = R'(i);
      if ((i & (i - 1)) != 0) begin
        d = d | (K'(c[idx]) << k);
        k++;
      end
    end
    return d;
  endfunction

  logic             s1_valid_q;
  logic [R-1:0]     s1_syn_q;
  logic             s1_par_q;
  logic [N-1:0]     s1_code_q;
  logic             s1_corr_q;
  logic             s2_valid_q;
  logic [K-1:0]     s2_data_q;
  logic             s2_single_q;
  logic             s2_double_q;
  logic [R-1:0]     s2_pos_q;
  logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
  logic [CNT_W-1:0] double_cnt_q, double_cnt_d;

  logic             s2_free, s1_adv, in_fire, out_fire;
  logic [R-1:0]     syn_d;
  logic             par_d;
  logic [K-1:0]     data_d;
  logic             single_d, double_d;

  // Backpressure looks only at occupancy and out_ready, never at in_valid.
  assign out_fire   = s2_valid_q & out_ready_i;
  assign s2_free    = ~s2_valid_q | out_ready_i;
  assign s1_adv     = s1_valid_q & s2_free;
  assign in_ready_o = ~s1_valid_q | s2_free;
  assign in_fire    = in_valid_i & in_ready_o;

  assign syn_d = syndrome(code_in_i);
  assign par_d = ^code_in_i;

  // A parity-position flip (or syndrome 0) leaves the data bits untouched after extraction.
  always_comb begin
    single_d = s1_par_q;
    double_d = ~s1_par_q & (s1_syn_q != '0);
    data_d   = extract_data(s1_code_q ^ ((s1_corr_q & s1_par_q) ? (N'(1) << s1_syn_q) : '0));
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    if (cnt_clr_i) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end else if (out_fire) begin
      if (s2_single_q && single_cnt_q != CNT_MAX) single_cnt_d = single_cnt_q + CNT_W'(1);
      if (s2_double_q && double_cnt_q != CNT_MAX) double_cnt_d = double_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: payload registers are reset too, because the outputs must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s1_code_q  <= '0;
      s1_corr_q  <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_syn_q   <= syn_d;
      s1_par_q   <= par_d;
      s1_code_q  <= code_in_i;
      s1_corr_q  <= corr_en_i;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_single_q <= 1'b0;
      s2_double_q <= 1'b0;
      s2_pos_q    <= '0;
    end else if (s1_adv) begin
      s2_valid_q  <= 1'b1;
      s2_data_q   <= data_d;
      s2_single_q <= single_d;
      s2_double_q <= double_d;
      s2_pos_q    <= s1_syn_q;
    end else if (out_fire) begin
      s2_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  assign out_valid_o  = s2_valid_q;
  assign data_out_o   = s2_data_q;
  assign err_single_o = s2_single_q;
  assign err_double_o = s2_double_q;
  assign err_pos_o    = s2_pos_q;
  assign single_cnt_o = single_cnt_q;
  assign double_cnt_o = double_cnt_q;

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Randomized bench for the SECDED stream decoder (R=3, narrow counters for saturation).
// Expected results come from the injected error positions, not from a syndrome calculation.
module tb_hamming_secded_stream_decoder;

  localparam int R     = 3;
  localparam int N     = 8;
  localparam int K     = 4;
  localparam int CNT_W = 5;
  localparam int CMAX  = 2**CNT_W - 1;

  typedef struct packed {
    logic [K-1:0] data;
    logic         single;
    logic         dbl;
    logic [R-1:0] pos;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     code_in = '0;
  logic             corr_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [K-1:0]     data_out;
  logic             err_single;
  logic             err_double;
  logic [R-1:0]     err_pos;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] single_cnt;
  logic [CNT_W-1:0] double_cnt;

  hamming_secded_stream_decoder #(.R(R), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .code_in_i    (code_in),
    .corr_en_i    (corr_en),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .data_out_o   (data_out),
    .err_single_o (err_single),
    .err_double_o (err_double),
    .err_pos_o    (err_pos),
    .cnt_clr_i    (cnt_clr),
    .single_cnt_o (single_cnt),
    .double_cnt_o (double_cnt)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  exp_t hold_w;
  exp_t obs_w;
  exp_t pop_w;
  bit   hold_v = 1'b0;
  bit   rnd_ready = 1'b0;
  int   model_single = 0;
  int   model_double = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Extended Hamming layout for R=3: {d3,d2,d1,p4,d0,p2,p1,p0}.
  function automatic logic [N-1:0] encode(input logic [K-1:0] d);
    logic p1, p2, p4, p0;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    p0 = ^{d, p1, p2, p4};
    return {d[3], d[2], d[1], p4, d[0], p2, p1, p0};
  endfunction

  function automatic logic [K-1:0] raw_data(input logic [N-1:0] c);
    return {c[7], c[6], c[5], c[3]};
  endfunction

  function automatic exp_t mk_exp(input logic [K-1:0] d, input logic s, input logic db,
                                  input logic [R-1:0] p);
    exp_t e;
    e.data = d; e.single = s; e.dbl = db; e.pos = p;
    return e;
  endfunction

  // Scoreboard, counter model and handshake checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_single = 0;
      model_double = 0;
      hold_v = 1'b0;
    end else begin
      obs_w = mk_exp(data_out, err_single, err_double, err_pos);
      check("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 2 && !out_ready)));
      if (exp_q.size() == 0) check("idle_out_valid", 32'(out_valid), 0);
      if (hold_v) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_word", 32'(obs_w), 32'(hold_w));
      end
      check("single_cnt", 32'(single_cnt), 32'(model_single));
      check("double_cnt", 32'(double_cnt), 32'(model_double));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        pop_w = exp_q.pop_front();
        check("word", 32'(obs_w), 32'(pop_w));
        if (pop_w.single && model_single < CMAX) model_single++;
        if (pop_w.dbl && model_double < CMAX) model_double++;
      end
      if (cnt_clr) begin
        model_single = 0;
        model_double = 0;
      end
      hold_v = out_valid && !out_ready;
      hold_w = obs_w;
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the word has been accepted.
  task automatic send(input logic [N-1:0] code, input logic corr, input exp_t e);
    int n = 0;
    code_in = code; corr_en = corr; cur_exp = e; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input int nerr);
    logic [K-1:0] d;
    logic [N-1:0] c;
    logic         corr;
    int           e1, e2;
    exp_t         e;
    d    = K'($urandom);
    corr = 1'($urandom_range(0, 1));
    e1   = $urandom_range(0, N - 1);
    e2   = (e1 + $urandom_range(1, N - 1)) % N;
    c    = encode(d);
    if (nerr >= 1) c = c ^ (N'(1) << e1);
    if (nerr >= 2) c = c ^ (N'(1) << e2);
    case (nerr)
      0:       e = mk_exp(d, 1'b0, 1'b0, '0);
      1:       e = mk_exp(corr ? d : raw_data(c), 1'b1, 1'b0, R'(e1));
      default: e = mk_exp(raw_data(c), 1'b0, 1'b1, R'(e1 ^ e2));
    endcase
    send(c, corr, e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_data_flags", {data_out, err_single, err_double, err_pos}, 0);
    check("rst_counters", {single_cnt, double_cnt}, 0);
    sync();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    sync();

    // Directed words: latency, single at data/parity position, double.
    send(8'hAA, 1'b1, mk_exp(4'hB, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    check("lat_s1_not_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_s2_valid", 32'(out_valid), 1);
    check("lat_data", 32'(data_out), 32'hB);
    sync();
    send(8'h8A, 1'b1, mk_exp(4'hB, 1'b1, 1'b0, 3'd5));
    send(8'h8A, 1'b0, mk_exp(4'h9, 1'b1, 1'b0, 3'd5));
    send(8'hCA, 1'b1, mk_exp(4'hD, 1'b0, 1'b1, 3'd3));
    send(8'hAB, 1'b1, mk_exp(4'hB, 1'b1, 1'b0, 3'd0));
    drain();
    check("dir_single_cnt", 32'(single_cnt), 3);
    check("dir_double_cnt", 32'(double_cnt), 1);
    sync();

    // Back-to-back random words under random backpressure.
    rnd_ready = 1'b1;
    repeat (10) send_rand($urandom_range(0, 2));
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) sync();
      send_rand($urandom_range(0, 2));
    end
    drain();
    rnd_ready = 1'b0;
    sync();
    out_ready = 1'b1;

    // Saturation of the single-error counter, then clear colliding with a counted transfer.
    repeat (CMAX + 8) send_rand(1);
    drain();
    check("sat_single_cnt", 32'(single_cnt), CMAX);
    sync();
    out_ready = 1'b0;
    send_rand(1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("clr_word_ready", 32'(out_valid), 1);
    sync();
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    sync();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_single_cnt", 32'(single_cnt), 0);
    sync();

    // Reset with two words in flight.
    send_rand(2);
    drain();
    sync();
    out_ready = 1'b0;
    send_rand(1);
    send_rand(0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_counters", {single_cnt, double_cnt}, 0);
    repeat (2) sync();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) sync();
    send(8'hAA, 1'b1, mk_exp(4'hB, 1'b0, 1'b0, 3'd0));
    drain();
    check("post_rst_clean_cnt", 32'(single_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
